// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, writes it word by word into
// instruction memory, then releases the core. Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINISH = CSUM;
`else
    localparam state_t FINISH = DONE;
`endif
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic        we_q;
    logic        accept;
    logic [15:0] len_n;
    logic        last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept    = byte_valid_i && byte_ready_o;
    assign len_n     = {byte_i, len_lo};
    assign last_word = ({1'b0, word_idx} + 17'd1) >= {1'b0, len};

    // A reset landing on the WRITE cycle must keep the strobe from reaching the memory.
    assign mem_we_o  = we_q && !rst_i;

    function automatic logic ready_in(input state_t s);
        case (s)
            LEN0, LEN1, DATA: ready_in = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM:             ready_in = 1'b1;
`endif
            default:          ready_in = 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            LEN0:  if (accept) state_nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, len_n} > MAX_W) state_nxt = ERROR;
                    else if (len_n == 16'd0)   state_nxt = FINISH;
                    else                       state_nxt = DATA;
                end
            end
            DATA:  if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
            WRITE: state_nxt = last_word ? FINISH : DATA;
`ifdef LOADER_CHECKSUM_EN
            CSUM:  if (accept) state_nxt = (byte_i == csum) ? DONE : ERROR;
`endif
            default: state_nxt = state;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
        if (rst_i) begin
            state        <= LEN0;
            byte_ready_o <= 1'b1;
            we_q         <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            core_rst_o   <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            len_lo       <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state        <= state_nxt;
            byte_ready_o <= ready_in(state_nxt);
            we_q         <= (state_nxt == WRITE);
            core_rst_o   <= (state_nxt != DONE);
            busy_o       <= (state_nxt != DONE) && (state_nxt != ERROR);
            done_o       <= (state_nxt == DONE);
            error_o      <= (state_nxt == ERROR);

            if (accept) begin
                case (state)
                    LEN0: len_lo <= byte_i;
                    LEN1: len    <= len_n;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_i;
`endif
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= byte_i;
                            2'd1: word_buf[15:8]  <= byte_i;
                            2'd2: word_buf[23:16] <= byte_i;
                            default: begin
                                mem_addr_o  <= {14'd0, word_idx, 2'b00};
                                mem_wdata_o <= {byte_i, word_buf};
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if (state == WRITE) word_idx <= word_idx + 16'd1;
        end
    end

endmodule
